lcd_ctrl: RTL and testbench

Hardware sequencer downstream of the core's LCD output register (o_io_lcd). It converts toggle-handshaked command words into HD44780-style bus cycles with correct setup, enable-pulse, hold and execution timing. Firmware no longer bit-bangs the enable line. A small FIFO lets firmware issue short bursts without polling.

---
 rtl/lcd_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-style bus sequencer fed by a toggle-handshaked command register.
// Commands {RS,RW,DATA} are queued in a small FIFO and replayed with setup,
// enable-pulse, hold and execution timing. All outputs are registered.
// Optional build macro LCD_INIT_EN: run a power-up wait plus a fixed init
// sequence (0x38, 0x0C, 0x01, 0x06) before the first IDLE.
module lcd_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned T_SETUP      = 2,
    parameter int unsigned T_PULSE      = 12,
    parameter int unsigned T_HOLD       = 2,
    parameter int unsigned T_EXEC_SHORT = 2000,
    parameter int unsigned T_EXEC_LONG  = 80000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_reg,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overflow
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned TMAX = max2(max2(max2(T_SETUP, T_PULSE), max2(T_HOLD, T_EXEC_SHORT)), T_EXEC_LONG);
    localparam int unsigned CW   = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC, PWRUP} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      data_q;
    logic            rs_q, rw_q, en_q, on_q, busy_q, ovf_q;
    logic            toggle_q;
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic            empty, full, toggled, push, pop;
    logic            exec_done, init_more, idle_next, busy_d;
    logic            unused_bits;

`ifdef LCD_INIT_EN
    logic            init_q;
    logic [2:0]      init_idx_q;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    assign unused_bits = ^i_lcd_reg[30:11];

    // FIFO status, handshake detect and next-state summary for o_busy
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        toggled   = (i_lcd_reg[10] != toggle_q);
        push      = toggled && !full;
        pop       = (state_q == IDLE) && !empty;
        wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
        exec_done = (state_q == EXEC) && (cnt_q == '0);
`ifdef LCD_INIT_EN
        init_more = init_q && (init_idx_q != 3'd4);
`else
        init_more = 1'b0;
`endif
        idle_next = ((state_q == IDLE) && !pop) || (exec_done && !init_more);
        busy_d    = (wr_ptr_d != rd_ptr_d) || !idle_next;
    end

    // Command storage (no reset needed; validity comes from the pointers)
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_lcd_reg[9:0];
    end

    // Toggle capture, FIFO pointers and sticky overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            toggle_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            toggle_q <= i_lcd_reg[10];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (toggled && full) ovf_q <= 1'b1;
        end
    end

    // Bus sequencer FSM with registered bus, strobe, power and busy outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
`ifdef LCD_INIT_EN
            state_q    <= PWRUP;
            cnt_q      <= CW'(T_EXEC_LONG - 1);
            init_q     <= 1'b1;
            init_idx_q <= '0;
`else
            state_q    <= IDLE;
            cnt_q      <= '0;
`endif
            data_q     <= '0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            en_q       <= 1'b0;
            on_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            on_q   <= i_lcd_reg[31];
            busy_q <= busy_d;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        {rs_q, rw_q, data_q} <= mem_q[rd_ptr_q[AW-1:0]];
                        cnt_q   <= CW'(T_SETUP - 1);
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b1;
                        cnt_q   <= CW'(T_PULSE - 1);
                        state_q <= PULSE;
                    end else cnt_q <= cnt_q - 1'b1;
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b0;
                        cnt_q   <= CW'(T_HOLD - 1);
                        state_q <= HOLD;
                    end else cnt_q <= cnt_q - 1'b1;
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= (!rs_q && data_q[7:2] == '0) ? CW'(T_EXEC_LONG - 1)
                                                                : CW'(T_EXEC_SHORT - 1);
                        state_q <= EXEC;
                    end else cnt_q <= cnt_q - 1'b1;
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (init_more) begin
`ifdef LCD_INIT_EN
                        {rs_q, rw_q, data_q} <= {2'b00, init_rom(init_idx_q)};
                        init_idx_q <= init_idx_q + 3'd1;
                        cnt_q      <= CW'(T_SETUP - 1);
                        state_q    <= SETUP;
`endif
                    end else begin
`ifdef LCD_INIT_EN
                        init_q  <= 1'b0;
`endif
                        state_q <= IDLE;
                    end
                end
                PWRUP: begin
`ifdef LCD_INIT_EN
                    if (cnt_q == '0) begin
                        {rs_q, rw_q, data_q} <= {2'b00, init_rom(3'd0)};
                        init_idx_q <= 3'd1;
                        cnt_q      <= CW'(T_SETUP - 1);
                        state_q    <= SETUP;
                    end else cnt_q <= cnt_q - 1'b1;
`else
                    state_q <= IDLE;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = rw_q;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_busy     = busy_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed testbench for lcd_ctrl with short timing parameters.
module tb_lcd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lcd_reg = 32'h8000_0000;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, overflow;

    lcd_ctrl #(
        .FIFO_DEPTH  (4),
        .T_SETUP     (2),
        .T_PULSE     (4),
        .T_HOLD      (2),
        .T_EXEC_SHORT(8),
        .T_EXEC_LONG (20)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_lcd_reg (lcd_reg),
        .o_lcd_data(lcd_data),
        .o_lcd_rs  (lcd_rs),
        .o_lcd_rw  (lcd_rw),
        .o_lcd_en  (lcd_en),
        .o_lcd_on  (lcd_on),
        .o_busy    (busy),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic       tog = 1'b0;
    logic [9:0] pend[$];
    logic       en_a   [0:199];
    logic       busy_a [0:199];
    logic       rs_a   [0:199];
    logic       rw_a   [0:199];
    logic [7:0] data_a [0:199];

    int         pulses, busy_end;
    int         rise_c  [0:7];
    int         width_c [0:7];
    logic [7:0] rise_d  [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic [9:0] c);
        tog = ~tog;
        lcd_reg = {1'b1, 20'b0, tog, c};
    endtask

    // Cycle 0 is the cycle in which the first queued command is presented.
    task automatic capture(input int n);
        if (pend.size() > 0) drive_cmd(pend.pop_front());
        en_a[0] = lcd_en; busy_a[0] = busy; rs_a[0] = lcd_rs; rw_a[0] = lcd_rw; data_a[0] = lcd_data;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            en_a[c] = lcd_en; busy_a[c] = busy; rs_a[c] = lcd_rs; rw_a[c] = lcd_rw; data_a[c] = lcd_data;
            if (pend.size() > 0) drive_cmd(pend.pop_front());
        end
    endtask

    task automatic analyze(input int n);
        pulses = 0;
        busy_end = 0;
        for (int i = 0; i < 8; i++) begin rise_c[i] = 0; width_c[i] = 0; rise_d[i] = 8'h00; end
        for (int c = 1; c <= n; c++) begin
            if (en_a[c] && !en_a[c-1]) begin
                if (pulses < 8) begin rise_c[pulses] = c; rise_d[pulses] = data_a[c]; end
                pulses++;
            end
            if (en_a[c] && pulses > 0 && pulses <= 8) width_c[pulses-1]++;
            if (busy_a[c]) busy_end = c + 1;
        end
    endtask

    initial begin
        // 1: reset state and power bit
        @(negedge clk); @(negedge clk);
        check("rst_on", 32'(lcd_on), 32'd0);
        check("rst_en", 32'(lcd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data", 32'(lcd_data), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("on_after_rel", 32'(lcd_on), 32'd1);
        check("idle_en", 32'(lcd_en), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // 2: data write 0x41, RS=1
        pend.push_back({1'b1, 1'b0, 8'h41});
        capture(30);
        analyze(30);
        check("t2_pulses", 32'(pulses), 32'd1);
        check("t2_rise", 32'(rise_c[0]), 32'd4);
        check("t2_width", 32'(width_c[0]), 32'd4);
        check("t2_data", 32'(data_a[4]), 32'h41);
        check("t2_rs", 32'(rs_a[4]), 32'd1);
        check("t2_rw", 32'(rw_a[4]), 32'd0);
        check("t2_busy_c1", 32'(busy_a[1]), 32'd1);
        check("t2_busy_end", 32'(busy_end), 32'd18);
        check("t2_hold_bus", 32'(data_a[9]), 32'h41);

        // 3: clear display -> long exec
        pend.push_back({1'b0, 1'b0, 8'h01});
        capture(40);
        analyze(40);
        check("t3_pulses", 32'(pulses), 32'd1);
        check("t3_rise", 32'(rise_c[0]), 32'd4);
        check("t3_busy_end", 32'(busy_end), 32'd30);

        // 4: display control 0x0C -> short exec
        pend.push_back({1'b0, 1'b0, 8'h0C});
        capture(30);
        analyze(30);
        check("t4_pulses", 32'(pulses), 32'd1);
        check("t4_busy_end", 32'(busy_end), 32'd18);
        check("t4_ovf", 32'(overflow), 32'd0);

        // 5: six back-to-back toggles, last one dropped
        for (int i = 0; i < 6; i++) pend.push_back({1'b1, 1'b0, 8'hA0 + 8'(i)});
        capture(120);
        analyze(120);
        check("t5_pulses", 32'(pulses), 32'd5);
        check("t5_rise0", 32'(rise_c[0]), 32'd4);
        check("t5_rise1", 32'(rise_c[1]), 32'd21);
        check("t5_rise4", 32'(rise_c[4]), 32'd72);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_data%0d", i), 32'(rise_d[i]), 32'hA0 + 32'(i));
            check($sformatf("t5_width%0d", i), 32'(width_c[i]), 32'd4);
        end
        check("t5_busy_end", 32'(busy_end), 32'd86);
        check("t5_ovf", 32'(overflow), 32'd1);

        // 6: reset asserted during PULSE with one command queued
        pend.push_back({1'b1, 1'b0, 8'h55});
        pend.push_back({1'b1, 1'b0, 8'h66});
        capture(5);
        check("t6_en_pre", 32'(en_a[5]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_en_async", 32'(lcd_en), 32'd0);
        check("t6_busy_async", 32'(busy), 32'd0);
        lcd_reg = 32'h8000_0000;
        tog = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        capture(40);
        analyze(40);
        check("t6_pulses", 32'(pulses), 32'd0);
        check("t6_busy_end", 32'(busy_end), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_data", 32'(lcd_data), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
